matmul_sequencer: RTL and testbench

MATMUL_SEQUENCER -- requirements
Module: matmul_sequencer

---
 rtl/matmul_pkg.sv | 25 ++
 rtl/matmul_sequencer_if.sv | 31 +++
 rtl/matmul_tx_serializer.sv | 50 +++++
 rtl/matmul_sequencer.sv | 132 +++++++++++++
 tb/tb_matmul_sequencer.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/matmul_pkg.sv
// Shared sizes, state encoding and byte-formatting helper for the matmul UART sequencer.
// Operands are 3x3 matrices of 3-bit elements. Results are 3x3 matrices of 6-bit elements.
package matmul_pkg;
    localparam int N_ELEM    = 9;
    localparam int ELEM_W    = 3;
    localparam int RES_W     = 6;
    localparam int MAT_W     = N_ELEM * ELEM_W;
    localparam int RES_BUS_W = N_ELEM * RES_W;
    localparam int CNT_W     = 4;

    localparam logic [CNT_W-1:0] LAST_ELEM = CNT_W'(N_ELEM - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD_A  = 3'd1,
        S_LOAD_B  = 3'd2,
        S_RUN     = 3'd3,
        S_CAPTURE = 3'd4,
        S_SEND    = 3'd5
    } state_t;

    function automatic logic [7:0] res_byte(input logic [RES_W-1:0] r);
        return {{(8 - RES_W){1'b0}}, r};
    endfunction
endpackage

// File: rtl/matmul_sequencer_if.sv
// UART byte streams, multiplier operand/result buses and status flags of the matmul sequencer.
// master = sequencer side; slave = UART, multiplier and host side.
interface matmul_sequencer_if;
    import matmul_pkg::*;

    logic [7:0]           rx_data;
    logic                 rx_valid;
    logic [7:0]           tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic [MAT_W-1:0]     mm_matrixA;
    logic [MAT_W-1:0]     mm_matrixB;
    logic                 mm_start;
    logic [RES_BUS_W-1:0] mm_result;
    logic                 busy;
    logic                 done;
    logic                 timeout;
    logic                 rx_overrun;

    modport master (
        input  rx_data, rx_valid, tx_ready, mm_result,
        output tx_data, tx_valid, mm_matrixA, mm_matrixB, mm_start,
               busy, done, timeout, rx_overrun
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, mm_result,
        input  tx_data, tx_valid, mm_matrixA, mm_matrixB, mm_start,
               busy, done, timeout, rx_overrun
    );
endinterface

// File: rtl/matmul_tx_serializer.sv
// Captures the 9-element result and streams it out as bytes. The first byte is valid the cycle after capture.
// Each byte is held while tx_ready is low, and the next byte follows the cycle after each transfer.
module matmul_tx_serializer
    import matmul_pkg::*;
(
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            capture_i,
    input  logic [N_ELEM-1:0][RES_W-1:0]    result_i,
    input  logic                            tx_ready_i,
    output logic                            tx_valid_o,
    output logic [7:0]                      tx_data_o,
    output logic                            last_o
);
    logic [N_ELEM-1:0][RES_W-1:0] cap_q;
    logic [CNT_W-1:0]             idx_q;
    logic                         tx_valid_q;
    logic [7:0]                   tx_data_q;
    logic [CNT_W-1:0]             idx_nxt;
    logic                         xfer;

    assign xfer    = tx_valid_q & tx_ready_i;
    assign idx_nxt = idx_q + 1'b1;
    assign last_o  = xfer && (idx_q == LAST_ELEM);

    always_ff @(posedge clk) begin
        if (rst) begin
            cap_q      <= '0;
            idx_q      <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
        end else if (capture_i) begin
            cap_q      <= result_i;
            idx_q      <= '0;
            tx_valid_q <= 1'b1;
            tx_data_q  <= res_byte(result_i[0]);
        end else if (xfer) begin
            if (idx_q == LAST_ELEM) begin
                tx_valid_q <= 1'b0;
                idx_q      <= '0;
            end else begin
                idx_q     <= idx_nxt;
                tx_data_q <= res_byte(cap_q[idx_nxt]);
            end
        end
    end

    assign tx_valid_o = tx_valid_q;
    assign tx_data_o  = tx_data_q;
endmodule

// File: rtl/matmul_sequencer.sv
// Loads A then B (9 UART bytes each), pulses mm_start, captures the result and sends 9 result bytes.
// All outputs are registered. TX holds each byte under tx_ready backpressure. RX bytes arriving outside loading are dropped and flagged.
module matmul_sequencer
    import matmul_pkg::*;
#(
    parameter int RX_TIMEOUT = 1000000,
    parameter int START_HOLD = 2
) (
    input  logic               clk,
    input  logic               rst,
    matmul_sequencer_if.master bus
);
    localparam int TO_W   = (RX_TIMEOUT > 0) ? $clog2(RX_TIMEOUT + 1) : 1;
    localparam int HOLD_W = (START_HOLD > 1) ? $clog2(START_HOLD) : 1;
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'((RX_TIMEOUT > 0) ? RX_TIMEOUT - 1 : 0);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((START_HOLD > 0) ? START_HOLD - 1 : 0);

    state_t                        state_q;
    logic [CNT_W-1:0]              cnt_q;
    logic [TO_W-1:0]               idle_q;
    logic [HOLD_W-1:0]             hold_q;
    logic [N_ELEM-1:0][ELEM_W-1:0] mat_a_q;
    logic [N_ELEM-1:0][ELEM_W-1:0] mat_b_q;
    logic                          mm_start_q;
    logic                          done_q;
    logic                          timeout_q;
    logic                          overrun_q;
    logic                          ser_last;
    logic                          ser_tx_valid;
    logic [7:0]                    ser_tx_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            idle_q     <= '0;
            hold_q     <= '0;
            mat_a_q    <= '0;
            mat_b_q    <= '0;
            mm_start_q <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            if (bus.rx_valid && (state_q inside {S_RUN, S_CAPTURE, S_SEND}))
                overrun_q <= 1'b1;

            case (state_q)
                S_IDLE: begin
                    idle_q <= '0;
                    if (bus.rx_valid) begin
                        mat_a_q[0] <= bus.rx_data[ELEM_W-1:0];
                        overrun_q  <= 1'b0;
                        cnt_q      <= CNT_W'(1);
                        state_q    <= S_LOAD_A;
                    end
                end
                S_LOAD_A, S_LOAD_B: begin
                    if (bus.rx_valid) begin
                        idle_q <= '0;
                        if (state_q == S_LOAD_A)
                            mat_a_q[cnt_q] <= bus.rx_data[ELEM_W-1:0];
                        else
                            mat_b_q[cnt_q] <= bus.rx_data[ELEM_W-1:0];
                        if (cnt_q == LAST_ELEM) begin
                            cnt_q <= '0;
                            if (state_q == S_LOAD_A) begin
                                state_q <= S_LOAD_B;
                            end else begin
                                state_q    <= S_RUN;
                                mm_start_q <= 1'b1;
                                hold_q     <= '0;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end else if (RX_TIMEOUT != 0) begin
                        // Abandon a stalled frame; operands keep their partial contents.
                        if (idle_q == TO_LAST) begin
                            state_q   <= S_IDLE;
                            timeout_q <= 1'b1;
                            cnt_q     <= '0;
                            idle_q    <= '0;
                        end else begin
                            idle_q <= idle_q + 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (hold_q == HOLD_LAST) begin
                        mm_start_q <= 1'b0;
                        hold_q     <= '0;
                        state_q    <= S_CAPTURE;
                    end else begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
                S_CAPTURE: state_q <= S_SEND;
                S_SEND: begin
                    if (ser_last) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    matmul_tx_serializer u_tx_ser (
        .clk        (clk),
        .rst        (rst),
        .capture_i  (state_q == S_CAPTURE),
        .result_i   (bus.mm_result),
        .tx_ready_i (bus.tx_ready),
        .tx_valid_o (ser_tx_valid),
        .tx_data_o  (ser_tx_data),
        .last_o     (ser_last)
    );

    assign bus.tx_valid   = ser_tx_valid;
    assign bus.tx_data    = ser_tx_data;
    assign bus.mm_matrixA = mat_a_q;
    assign bus.mm_matrixB = mat_b_q;
    assign bus.mm_start   = mm_start_q;
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.done       = done_q;
    assign bus.timeout    = timeout_q;
    assign bus.rx_overrun = overrun_q;
endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed bench for matmul_sequencer with a behavioural 3x3 multiplier beside it.
// Expected TX bytes are queued at stimulus time and are popped on each transfer.
module tb_matmul_sequencer;
    import matmul_pkg::*;

    localparam int TO   = 16;
    localparam int HOLD = 2;

    typedef byte unsigned mat_t [9];

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    matmul_sequencer_if bus ();

    matmul_sequencer #(.RX_TIMEOUT(TO), .START_HOLD(HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // External multiplier: combinational 3x3 product, with results truncated to 6 bits.
    logic [RES_BUS_W-1:0] mm_res;
    always_comb begin
        int acc;
        acc    = 0;
        mm_res = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                acc = 0;
                for (int k = 0; k < 3; k++)
                    acc = acc + int'(bus.mm_matrixA[(i*3+k)*3 +: 3]) * int'(bus.mm_matrixB[(k*3+j)*3 +: 3]);
                mm_res[(i*3+j)*6 +: 6] = 6'(acc);
            end
        end
    end
    assign bus.mm_result = mm_res;

    int          checks = 0;
    int          errors = 0;
    byte unsigned exp_q[$];
    int          xfer_cnt = 0;
    int          done_cnt = 0;
    int          run_len = 0;
    logic        mm_start_seen = 1'b0;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (prev_stall && bus.tx_valid)
                check("tx_hold_stable", 64'(bus.tx_data), 64'(prev_data));
            if (bus.tx_valid && bus.tx_ready) begin
                xfer_cnt++;
                check("tx_expected_pending", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0)
                    check("tx_byte", 64'(bus.tx_data), 64'(exp_q.pop_front()));
            end
            if (bus.mm_start) begin
                run_len++;
                mm_start_seen = 1'b1;
            end else if (run_len != 0) begin
                check("mm_start_len", 64'(run_len), 64'(HOLD));
                run_len = 0;
            end
            if (bus.done) done_cnt++;
            prev_stall = bus.tx_valid && !bus.tx_ready;
            prev_data  = bus.tx_data;
        end else begin
            prev_stall = 1'b0;
            run_len    = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input byte unsigned b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_frame(input mat_t a, input mat_t b, input bit chk_ovr);
        for (int k = 0; k < 9; k++) begin
            send_byte(a[k]);
            if (k == 0 && chk_ovr) check("overrun_clear", 64'(bus.rx_overrun), 64'd0);
        end
        for (int k = 0; k < 9; k++) send_byte(b[k]);
    endtask

    task automatic ref_mul(input mat_t a, input mat_t b, output mat_t c);
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                int s;
                s = 0;
                for (int k = 0; k < 3; k++) s += (a[i*3+k] & 7) * (b[k*3+j] & 7);
                c[i*3+j] = byte'(s % 64);
            end
    endtask

    task automatic push_exp(input mat_t c);
        for (int k = 0; k < 9; k++) exp_q.push_back(c[k]);
    endtask

    task automatic rand_mat(output mat_t m);
        for (int k = 0; k < 9; k++) m[k] = byte'($urandom_range(0, 255));
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!bus.done && n < 300) begin
            tick();
            n++;
        end
        check(tag, 64'(bus.done), 64'd1);
    endtask

    task automatic wait_tx_valid(input string tag);
        int n;
        n = 0;
        while (!bus.tx_valid && n < 100) begin
            tick();
            n++;
        end
        check(tag, 64'(bus.tx_valid), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        mat_t a, b, c;
        int   n, x0;

        rst          = 1'b1;
        bus.rx_data  = '0;
        bus.rx_valid = 1'b0;
        bus.tx_ready = 1'b0;
        repeat (2) tick();
        bus.rx_data  = 8'h05;
        bus.rx_valid = 1'b1;
        tick();
        rst          = 1'b0;
        bus.rx_valid = 1'b0;

        check("rst_tx_valid", 64'(bus.tx_valid), 64'd0);
        check("rst_tx_data", 64'(bus.tx_data), 64'd0);
        check("rst_mm_start", 64'(bus.mm_start), 64'd0);
        check("rst_matA", 64'(bus.mm_matrixA), 64'd0);
        check("rst_matB", 64'(bus.mm_matrixB), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_timeout", 64'(bus.timeout), 64'd0);
        check("rst_overrun", 64'(bus.rx_overrun), 64'd0);
        tick();
        check("rst_byte_dropped", 64'(bus.busy), 64'd0);

        // Identity
        a = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01};
        b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h00, 8'h01};
        bus.tx_ready = 1'b1;
        push_exp(b);
        send_frame(a, b, 1'b0);
        check("id_matA_held", 64'(bus.mm_matrixA), 64'h1001001);
        check("id_matB_held", 64'(bus.mm_matrixB), 64'h11F58D1);
        wait_done("id_done");
        tick();
        check("id_done_pulse", 64'(bus.done), 64'd0);
        check("id_done_count", 64'(done_cnt), 64'd1);
        check("id_drained", 64'(exp_q.size()), 64'd0);

        // Overflow with junk in the ignored upper bits
        a = '{default: 8'hFF};
        b = '{default: 8'h07};
        for (int k = 0; k < 9; k++) exp_q.push_back(8'h13);
        send_frame(a, b, 1'b0);
        wait_done("ovf_done");
        check("ovf_drained", 64'(exp_q.size()), 64'd0);

        // Backpressure
        rand_mat(a);
        rand_mat(b);
        ref_mul(a, b, c);
        push_exp(c);
        bus.tx_ready = 1'b0;
        x0 = xfer_cnt;
        send_frame(a, b, 1'b0);
        wait_tx_valid("bp_valid");
        repeat (10) tick();
        check("bp_still_valid", 64'(bus.tx_valid), 64'd1);
        check("bp_none_sent", 64'(xfer_cnt - x0), 64'd0);
        bus.tx_ready = 1'b1;
        repeat (3) tick();
        bus.tx_ready = 1'b0;
        repeat (10) tick();
        bus.tx_ready = 1'b1;
        wait_done("bp_done");
        check("bp_xfer_count", 64'(xfer_cnt - x0), 64'd9);
        check("bp_drained", 64'(exp_q.size()), 64'd0);

        // Overrun
        rand_mat(a);
        rand_mat(b);
        ref_mul(a, b, c);
        push_exp(c);
        bus.tx_ready = 1'b0;
        send_frame(a, b, 1'b0);
        wait_tx_valid("ovr_valid");
        send_byte(8'hAA);
        send_byte(8'h55);
        bus.tx_ready = 1'b1;
        wait_done("ovr_done");
        check("ovr_flag_set", 64'(bus.rx_overrun), 64'd1);
        check("ovr_drained", 64'(exp_q.size()), 64'd0);
        rand_mat(a);
        rand_mat(b);
        ref_mul(a, b, c);
        push_exp(c);
        send_frame(a, b, 1'b1);
        wait_done("ovr_next_done");

        // Timeout
        tick();
        mm_start_seen = 1'b0;
        for (int k = 0; k < 4; k++) send_byte(byte'(k + 1));
        n = 0;
        while (!bus.timeout && n < 40) begin
            tick();
            n++;
        end
        check("to_latency", 64'(n), 64'(TO));
        check("to_busy", 64'(bus.busy), 64'd0);
        check("to_no_start", 64'(mm_start_seen), 64'd0);
        tick();
        check("to_pulse", 64'(bus.timeout), 64'd0);
        rand_mat(a);
        rand_mat(b);
        ref_mul(a, b, c);
        push_exp(c);
        send_frame(a, b, 1'b0);
        wait_done("to_next_done");

        // Reset mid-SEND
        rand_mat(a);
        rand_mat(b);
        ref_mul(a, b, c);
        push_exp(c);
        bus.tx_ready = 1'b0;
        send_frame(a, b, 1'b0);
        wait_tx_valid("rst_send_valid");
        bus.tx_ready = 1'b1;
        repeat (3) tick();
        bus.tx_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_send_tx_valid", 64'(bus.tx_valid), 64'd0);
        check("rst_send_busy", 64'(bus.busy), 64'd0);
        check("rst_send_remaining", 64'(exp_q.size()), 64'd6);
        exp_q.delete();
        bus.tx_ready = 1'b1;
        rand_mat(a);
        rand_mat(b);
        ref_mul(a, b, c);
        push_exp(c);
        send_frame(a, b, 1'b0);
        wait_done("rst_next_done");
        tick();

        check("final_drained", 64'(exp_q.size()), 64'd0);
        check("final_done_count", 64'(done_cnt), 64'd7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
